// File: rtl/cordic_pkg.sv
// cordic_pkg: shared gain/angle constants, FSM encoding and arctangent table generator
// for the CORDIC family of blocks.
package cordic_pkg;
   typedef enum logic [1:0] {IDLE = 2'd0, ROTATE = 2'd1, DONE = 2'd2} state_t;
   localparam real K_GAIN = 0.607252935;
   localparam real PI_R = 3.141592653589793;
   function automatic real pow2(input int n);
      real p;
      p = 1.0;
      for (int k = 0; k < (n < 0 ? -n : n); k++) p = (n < 0) ? p / 2.0 : p * 2.0;
      return p;
   endfunction
   function automatic longint k_scaled(input int frac);
      return longint'(K_GAIN * pow2(frac));
   endfunction
   function automatic longint pi_bam(input int w);
      return longint'(1) << (w - 1);
   endfunction
   function automatic longint half_pi_bam(input int w);
      return longint'(1) << (w - 2);
   endfunction
   // atan(2^-i)/pi; past i=8 the two-term series is exact to well below one table LSB
   function automatic real atan_turns(input int i);
      real t;
      t = pow2(-i);
      case (i)
         0: return 0.25;
         1: return 0.147583617650433;
         2: return 0.077979130377369;
         3: return 0.039583424160566;
         4: return 0.019868524903955;
         5: return 0.009943846656982;
         6: return 0.004973135727724;
         7: return 0.002486745362278;
         8: return 0.001243393353662;
         default: return t * (1.0 - t * t / 3.0) / PI_R;
      endcase
   endfunction
   function automatic longint atan_bam(input int i, input int frac);
      return longint'(atan_turns(i) * pow2(frac));
   endfunction
endpackage

// File: rtl/cordic_atan_lut.sv
// cordic_atan_lut: combinational arctangent ROM in binary-angle units with GUARD extra LSBs.
module cordic_atan_lut
   import cordic_pkg::*;
#(
   parameter int WIDTH      = 18,
   parameter int GUARD      = 2,
   parameter int ITERATIONS = 16
) (
   input  logic [$clog2(ITERATIONS)-1:0] index,
   output logic signed [WIDTH+GUARD:0]   angle
);
   localparam int AW = WIDTH + GUARD + 1;
   localparam int N = 2 ** $clog2(ITERATIONS);
   logic signed [AW-1:0] rom [N];
   for (genvar g = 0; g < N; g++) begin : g_rom
      assign rom[g] = AW'(atan_bam(g, WIDTH - 1 + GUARD));
   end
   assign angle = rom[index];
endmodule

// File: rtl/cordic_rotator.sv
// cordic_rotator: iterative rotation-mode CORDIC; full-circle angle in, gain-compensated
// cosine and sine out with a start/ready/valid handshake.
module cordic_rotator
   import cordic_pkg::*;
#(
   parameter int WIDTH      = 18,
   parameter int ITERATIONS = 16,
   parameter int GUARD      = 2
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    start,
   input  logic signed [WIDTH-1:0] angle_in,
   output logic                    ready,
   output logic                    busy,
   output logic                    valid,
   output logic signed [WIDTH-1:0] cos_out,
   output logic signed [WIDTH-1:0] sin_out
);
   localparam int IW = WIDTH + GUARD + 1;
   localparam int CW = $clog2(ITERATIONS);
   localparam logic signed [IW-1:0] K0 = IW'(k_scaled(WIDTH - 2 + GUARD));
   localparam logic signed [IW-1:0] RND = IW'((longint'(1) << GUARD) >> 1);
   localparam logic signed [IW-1:0] SAT = IW'((longint'(1) << (WIDTH - 1)) - 1);
   localparam logic signed [WIDTH-1:0] HALF_PI = WIDTH'(half_pi_bam(WIDTH));
   localparam logic signed [WIDTH-1:0] PI = WIDTH'(pi_bam(WIDTH));
   state_t state;
   logic [CW-1:0] i;
   logic signed [IW-1:0] x, y, z, xs, ys, atan_i;
   logic signed [WIDTH-1:0] z0;
   logic fold;
   cordic_atan_lut #(.WIDTH(WIDTH), .GUARD(GUARD), .ITERATIONS(ITERATIONS)) u_lut (
      .index(i),
      .angle(atan_i)
   );
   function automatic logic signed [WIDTH-1:0] round_sat(input logic signed [IW-1:0] v);
      logic signed [IW-1:0] r;
      r = (v + RND) >>> GUARD;
      return (r > SAT) ? SAT[WIDTH-1:0] : (r < -SAT) ? WIDTH'(-SAT) : r[WIDTH-1:0];
   endfunction
   // Outside +-pi/2 rotate from the opposite half-plane: start at -K and subtract pi (mod 2^WIDTH).
   always_comb begin
      fold = angle_in > HALF_PI || angle_in < -HALF_PI;
      z0 = fold ? angle_in - PI : angle_in;
      xs = x >>> i;
      ys = y >>> i;
   end
   always_ff @(posedge clock) begin
      if (reset) begin
         state <= IDLE;
         ready <= 1'b1;
         busy <= 1'b0;
         valid <= 1'b0;
         cos_out <= '0;
         sin_out <= '0;
         i <= '0;
         x <= '0;
         y <= '0;
         z <= '0;
      end else begin
         valid <= 1'b0;
         case (state)
            IDLE: if (start) begin
               state <= ROTATE;
               ready <= 1'b0;
               busy <= 1'b1;
               x <= fold ? -K0 : K0;
               y <= '0;
               z <= IW'(z0) <<< GUARD;
               i <= '0;
            end
            ROTATE: begin
               x <= z[IW-1] ? x + ys : x - ys;
               y <= z[IW-1] ? y - xs : y + xs;
               z <= z[IW-1] ? z + atan_i : z - atan_i;
               i <= i + CW'(1);
               if (i == CW'(ITERATIONS - 1)) state <= DONE;
            end
            DONE: begin
               cos_out <= round_sat(x);
               sin_out <= round_sat(y);
               valid <= 1'b1;
               ready <= 1'b1;
               busy <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_cordic_rotator.sv
// tb_cordic_rotator: directed and randomized checks of cordic_rotator against a
// real-valued trigonometric model with cycle-level handshake expectations.
module tb_cordic_rotator;
   localparam int W = 18;
   localparam int N = 16;
   localparam int SW = 12;
   localparam int SN = 10;
   logic clock = 1'b0;
   always #5 clock = ~clock;
   logic reset = 1'b1;
   logic start = 1'b0;
   logic signed [W-1:0] angle_in = '0;
   logic ready, busy, valid;
   logic signed [W-1:0] cos_out, sin_out;
   logic s_start = 1'b0;
   logic signed [SW-1:0] s_angle = '0;
   logic s_ready, s_busy, s_valid;
   logic signed [SW-1:0] s_cos, s_sin;
   int total = 0;
   int bad = 0;
   bit chk_en = 1'b0;
   int m_cnt = 0;
   bit m_valid = 1'b0;
   bit m_zero = 1'b1;
   logic signed [W-1:0] m_ang = '0;
   real m_cos = 0.0;
   real m_sin = 0.0;

   cordic_rotator dut (
      .clock(clock), .reset(reset), .start(start), .angle_in(angle_in),
      .ready(ready), .busy(busy), .valid(valid), .cos_out(cos_out), .sin_out(sin_out)
   );
   cordic_rotator #(.WIDTH(SW), .ITERATIONS(SN)) dut_s (
      .clock(clock), .reset(reset), .start(s_start), .angle_in(s_angle),
      .ready(s_ready), .busy(s_busy), .valid(s_valid), .cos_out(s_cos), .sin_out(s_sin)
   );

   function automatic real ideal(input longint a, input int w, input bit sine);
      real th, v, lim;
      th = 3.141592653589793 * a / $pow(2.0, w - 1);
      v = (sine ? $sin(th) : $cos(th)) * $pow(2.0, w - 2);
      lim = $pow(2.0, w - 1) - 1.0;
      return v > lim ? lim : (v < -lim ? -lim : v);
   endfunction

   task automatic chk(input string nm, input longint act, input longint exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic near(input string nm, input longint act, input real exp);
      total++;
      if (act - exp > 4.0 || exp - act > 4.0) begin
         bad++;
         $display("FAIL %s: got %0d expected %0.2f +-4", nm, act, exp);
      end
   endtask

   // Model: an accepted start yields a result N+1 edges later; starts while busy are dropped.
   always @(posedge clock) begin
      m_valid <= 1'b0;
      if (reset) begin
         m_cnt <= 0;
         m_zero <= 1'b1;
      end else if (m_cnt == 0) begin
         if (start) begin
            m_cnt <= 1;
            m_ang <= angle_in;
         end
      end else if (m_cnt == N + 1) begin
         m_cnt <= 0;
         m_valid <= 1'b1;
         m_zero <= 1'b0;
         m_cos <= ideal(m_ang, W, 1'b0);
         m_sin <= ideal(m_ang, W, 1'b1);
      end else begin
         m_cnt <= m_cnt + 1;
      end
   end

   always @(negedge clock) begin
      if (chk_en) begin
         chk("ready", ready, m_cnt == 0);
         chk("busy", busy, m_cnt != 0);
         chk("valid", valid, m_valid);
         if (m_zero) begin
            chk("cos cleared", cos_out, 0);
            chk("sin cleared", sin_out, 0);
         end else begin
            near("cos", cos_out, m_cos);
            near("sin", sin_out, m_sin);
         end
      end
   end

   task automatic op(input logic signed [W-1:0] a);
      int lat;
      angle_in = a;
      start = 1'b1;
      @(posedge clock);
      #1 start = 1'b0;
      lat = 0;
      while (lat < 40 && !valid) begin
         @(posedge clock);
         #1 lat++;
      end
      chk("latency", lat, N + 1);
   endtask

   initial begin
      int nv, last, pulses;
      longint bnd [7];
      bnd = '{65536, -65536, 65537, -65537, -131072, 131071, 0};
      @(posedge clock);
      #1 chk_en = 1'b1;
      chk("rst ready", ready, 1);
      chk("rst busy", busy, 0);
      chk("rst valid", valid, 0);
      chk("rst cos", cos_out, 0);
      chk("rst sin", sin_out, 0);
      @(posedge clock);
      #1 reset = 1'b0;
      op(0);
      near("lit cos 0", cos_out, 65536.0);
      near("lit sin 0", sin_out, 0.0);
      op(32768);
      near("lit cos 45", cos_out, 46341.0);
      near("lit sin 45", sin_out, 46341.0);
      op(65536);
      near("lit cos 90", cos_out, 0.0);
      near("lit sin 90", sin_out, 65536.0);
      op(98304);
      near("lit cos 135", cos_out, -46341.0);
      near("lit sin 135", sin_out, 46341.0);
      op(-131072);
      near("lit cos -180", cos_out, -65536.0);
      near("lit sin -180", sin_out, 0.0);
      // start pulsed mid-operation with another angle must be dropped
      angle_in = 32768;
      start = 1'b1;
      @(posedge clock);
      #1 start = 1'b0;
      repeat (4) @(posedge clock);
      #1 angle_in = -60000;
      start = 1'b1;
      @(posedge clock);
      #1 start = 1'b0;
      nv = 0;
      repeat (30) begin
         @(posedge clock);
         #1 if (valid) nv++;
      end
      chk("ignored start valids", nv, 1);
      near("ignored start cos", cos_out, 46341.0);
      near("ignored start sin", sin_out, 46341.0);
      // continuous start: pulses N+2 apart
      start = 1'b1;
      angle_in = -40000;
      last = -1;
      pulses = 0;
      for (int c = 0; c < 80 && pulses < 3; c++) begin
         @(posedge clock);
         #1;
         if (valid) begin
            if (last >= 0) chk("b2b gap", c - last, N + 2);
            last = c;
            pulses++;
         end
      end
      start = 1'b0;
      chk("b2b pulses", pulses, 3);
      repeat (N + 4) @(posedge clock);
      // reset during iteration 7
      #1 angle_in = 20000;
      start = 1'b1;
      @(posedge clock);
      #1 start = 1'b0;
      repeat (7) @(posedge clock);
      #1 reset = 1'b1;
      @(posedge clock);
      #1 reset = 1'b0;
      chk("abort ready", ready, 1);
      chk("abort valid", valid, 0);
      chk("abort cos", cos_out, 0);
      chk("abort sin", sin_out, 0);
      nv = 0;
      repeat (30) begin
         @(posedge clock);
         #1 if (valid) nv++;
      end
      chk("abort no valid", nv, 0);
      op(-20000);
      // randomized traffic with boundary angles, stray starts and random resets
      for (int c = 0; c < 3000; c++) begin
         @(posedge clock);
         #1;
         reset = ($urandom_range(0, 299) == 0);
         start = ($urandom_range(0, 2) == 0);
         angle_in = ($urandom_range(0, 7) == 0) ? W'(bnd[$urandom_range(0, 6)]) : W'($urandom);
      end
      reset = 1'b0;
      start = 1'b0;
      repeat (N + 4) @(posedge clock);
      // narrow instance: full-circle sweep
      for (int k = 0; k < 64; k++) begin
         int lat;
         #1 s_angle = SW'(k * 64 - 2048);
         s_start = 1'b1;
         @(posedge clock);
         #1 s_start = 1'b0;
         lat = 0;
         while (lat < 40 && !s_valid) begin
            @(posedge clock);
            #1 lat++;
         end
         chk("s latency", lat, SN + 1);
         near("s cos", s_cos, ideal(s_angle, SW, 1'b0));
         near("s sin", s_sin, ideal(s_angle, SW, 1'b1));
         chk("s range", s_cos >= -2047 && s_sin >= -2047, 1);
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/cordic_rotator.md
Name: cordic_rotator

Overview:
- Iterative rotation-mode CORDIC engine: one angle in, cosine and sine out.
- Parametrised successor to the first-generation angle-accumulator CORDIC. Adds width and iteration parameters, full-circle input via quadrant folding, gain pre-compensation, a start/ready/valid handshake and synchronous reset.
- Sits between the angle source (phase accumulator or testbench) and downstream DSP consumers. One operation in flight at a time.

Parameters:
- WIDTH, 18, bit width of the angle input and the sin/cos outputs.
- ITERATIONS, 16, micro-rotations per operation. Legal range 4..WIDTH-2.
- GUARD, 2, extra LSBs carried internally on x/y/z to bound rounding error.

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only while ready=1.
- angle_in  input  WIDTH  signed binary angle: full scale ±2^(WIDTH-1) = ±pi, i.e. 2^(WIDTH-2) = pi/2.
- ready  output  1  high when idle and able to accept start.
- busy  output  1  high while an operation is in progress (busy = !ready).
- valid  output  1  one-cycle pulse: cos_out/sin_out hold a new result.
- cos_out  output  WIDTH  signed Q1.(WIDTH-2): 2^(WIDTH-2) = 1.0.
- sin_out  output  WIDTH  signed Q1.(WIDTH-2).

Behaviour:
- Clock and reset: one clock. Reset is synchronous and active-high.
- Reset values: state=IDLE, ready=1, busy=0, valid=0, cos_out=0, sin_out=0, iteration counter=0.
- Reset asserted mid-operation: the operation is abandoned, no valid pulse is produced, and outputs are cleared to 0.
- FSM states IDLE, ROTATE, DONE.
  - IDLE -> ROTATE on start=1 at an edge.
  - ROTATE -> DONE after ITERATIONS edges.
  - DONE -> IDLE after one cycle.
- Load (edge that samples start):
  - Quadrant fold: if angle_in > +pi/2 or angle_in < -pi/2, z0 = angle_in - pi with wrap-around in WIDTH bits, and x0 = -K.
  - Otherwise z0 = angle_in and x0 = +K.
  - K = round(0.607252935 * 2^(WIDTH-2+GUARD)).
  - y0 = 0. The counter i is cleared to 0.
- ROTATE, one micro-rotation per edge, for i = 0..ITERATIONS-1:
  - d = +1 if z >= 0, else -1.
  - x' = x - d*(y>>>i); y' = y + d*(x>>>i); z' = z - d*atan_lut(i).
  - Shifts are arithmetic. All arithmetic is two's complement at WIDTH+GUARD+1 bits.
- atan_lut(i) = round(atan(2^-i)/pi * 2^(WIDTH-1+GUARD)). Entries for i >= ITERATIONS are don't-care.
- DONE:
  - cos_out = x and sin_out = y, each rounded (add half-LSB, drop GUARD bits) and saturated to ±(2^(WIDTH-1)-1). Both are registered.
  - valid=1 for exactly this one cycle.
- Latency: valid is high in the cycle following edge t+ITERATIONS+1, where t is the sampling edge. busy is high from edge t until DONE exits.
- Outputs hold their last result until the next DONE or reset.
- start while busy is ignored, not queued. start held continuously begins a new operation on the edge after DONE (back-to-back throughput = ITERATIONS+2 cycles).
- angle_in is captured at load. Later changes during ROTATE have no effect.
- Boundary angles:
  - Exactly +pi/2 or -pi/2 is not folded.
  - -pi (most-negative code) folds to z0 = 0 with x0 = -K.
- Accuracy: |error| <= 4 LSB of the output format for the default parameters.

Decomposition:
- Shared package cordic_pkg holds:
  - The gain constant K as a real with a scaling function.
  - The binary-angle constants PI_BAM and HALF_PI_BAM as functions of WIDTH.
  - FSM state encoding (IDLE=0, ROTATE=1, DONE=2).
  - The atan table generator function.
- One sub-module: cordic_atan_lut (params WIDTH, GUARD, ITERATIONS; input index, output signed angle). Purely combinational ROM, reusable by the later vectoring-mode block.

Test Plan:
1. Default params, angle_in=0 -> after 18 cycles valid pulses once; cos_out=65536±4, sin_out=0±4; ready returns 1 the next cycle.
2. angle_in=32768 (45°) -> cos_out=46341±4, sin_out=46341±4. angle_in=65536 (+90°) -> cos_out=0±4, sin_out=65536±4, no fold.
3. Fold and wrap: angle_in=98304 (135°) -> cos_out=-46341±4, sin_out=46341±4. angle_in=-131072 (-pi) -> cos_out=-65536±4, sin_out=0±4.
4. start pulsed at cycle 5 of an operation with a different angle -> ignored. Exactly one valid with the first angle's result. Continuous start gives valid pulses exactly 18 cycles apart.
5. reset asserted during ROTATE (iteration 7) -> next cycle ready=1, valid=0, outputs 0, no later valid. A following start completes normally.
6. WIDTH=12, ITERATIONS=10 -> sweep 64 angles across the full circle; each result is within 4 LSB of a real-valued model, and no output exceeds ±2047.
